tpc_cmd_sequencer: RTL and testbench



---
 rtl/tpc_cmd_sequencer_pkg.sv | 27 ++
 rtl/tpc_cmd_sequencer_if.sv | 28 ++
 rtl/tpc_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_tpc_cmd_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpc_cmd_sequencer_pkg.sv
// Shared accelerator definitions for the TPC command sequencer: opcodes,
// FSM state encoding and default geometry.
package tpc_cmd_sequencer_pkg;

  localparam int TPC_PC_W          = 20;
  localparam int TPC_INSTR_W       = 32;
  localparam int TPC_FETCH_TIMEOUT = 1024;
  localparam int TPC_PAYLOAD_W     = 28;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_DISPATCH = 4'h1;
  localparam logic [3:0] OP_SYNC     = 4'h2;
  localparam logic [3:0] OP_WAIT     = 4'h3;
  localparam logic [3:0] OP_HALT     = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_DISPATCH,
    ST_SYNC,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/tpc_cmd_sequencer_if.sv
// Handshake bundle between the command sequencer and its instruction memory,
// execution-unit dispatch port and barrier controller.
interface tpc_cmd_sequencer_if
  import tpc_cmd_sequencer_pkg::*;
#(
  parameter int PC_W    = TPC_PC_W,
  parameter int INSTR_W = TPC_INSTR_W
);
  logic                     imem_req;
  logic [PC_W-1:0]          imem_addr;
  logic                     imem_valid;
  logic [INSTR_W-1:0]       imem_rdata;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [TPC_PAYLOAD_W-1:0] cmd_data;
  logic                     sync_request;
  logic                     sync_grant;

  modport master (
    output imem_req, imem_addr, cmd_valid, cmd_data, sync_request,
    input  imem_valid, imem_rdata, cmd_ready, sync_grant
  );

  modport slave (
    input  imem_req, imem_addr, cmd_valid, cmd_data, sync_request,
    output imem_valid, imem_rdata, cmd_ready, sync_grant
  );
endinterface

// File: rtl/tpc_cmd_sequencer.sv
// Instruction-driven command sequencer: fetches from imem, dispatches payloads,
// handles barrier sync and execution waits, reports busy/done/error.
module tpc_cmd_sequencer
  import tpc_cmd_sequencer_pkg::*;
#(
  parameter int PC_W          = TPC_PC_W,
  parameter int INSTR_W       = TPC_INSTR_W,
  parameter int FETCH_TIMEOUT = TPC_FETCH_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PC_W-1:0]     start_pc,
  input  logic                exec_busy,
  output logic                busy,
  output logic                done,
  output logic                error,
  tpc_cmd_sequencer_if.master bus
);
  // state       | meaning
  // ST_IDLE     | out of reset, waiting for start
  // ST_FETCH    | imem_req high at pc, timeout counter running
  // ST_EXEC     | decode the captured instruction
  // ST_DISPATCH | cmd_valid high with payload until cmd_ready
  // ST_SYNC     | sync_request high until sync_grant
  // ST_WAIT     | wait for exec_busy low (halt flag selects DONE)
  // ST_DONE     | program halted cleanly, done held until start
  // ST_ERROR    | bad opcode, fetch timeout or pc overflow

  localparam int               TMO_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(FETCH_TIMEOUT - 1);

  state_t                   state;
  logic [PC_W-1:0]          pc;
  logic [TMO_W-1:0]         tmo_cnt;
  logic [3:0]               op;
  logic [TPC_PAYLOAD_W-1:0] payload;
  logic                     halt;
  logic                     imem_req;
  logic                     cmd_valid;
  logic                     sync_request;
  logic [TPC_PAYLOAD_W-1:0] cmd_data;
  logic                     adv;

  assign bus.imem_req     = imem_req;
  assign bus.imem_addr    = pc;
  assign bus.cmd_valid    = cmd_valid;
  assign bus.cmd_data     = cmd_data;
  assign bus.sync_request = sync_request;

  // Instruction retired this cycle: move to pc+1 (or fault on overflow).
  always_comb begin
    adv = 1'b0;
    case (state)
      ST_EXEC:     adv = (op == OP_NOP);
      ST_DISPATCH: adv = bus.cmd_ready;
      ST_SYNC:     adv = bus.sync_grant;
      ST_WAIT:     adv = !exec_busy && !halt;
      default:     adv = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pc           <= '0;
      tmo_cnt      <= '0;
      op           <= '0;
      payload      <= '0;
      halt         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      imem_req     <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_data     <= '0;
      sync_request <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            pc       <= start_pc;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            imem_req <= 1'b1;
            tmo_cnt  <= TMO_LOAD;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.imem_valid) begin
            imem_req <= 1'b0;
            op       <= bus.imem_rdata[INSTR_W-1 -: 4];
            payload  <= bus.imem_rdata[TPC_PAYLOAD_W-1:0];
            state    <= ST_EXEC;
          end else if (tmo_cnt == '0) begin
            imem_req <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
            state    <= ST_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        ST_EXEC: begin
          case (op)
            OP_NOP: ;
            OP_DISPATCH: begin
              cmd_valid <= 1'b1;
              cmd_data  <= payload;
              state     <= ST_DISPATCH;
            end
            OP_SYNC: begin
              sync_request <= 1'b1;
              state        <= ST_SYNC;
            end
            OP_WAIT: begin
              halt  <= 1'b0;
              state <= ST_WAIT;
            end
            OP_HALT: begin
              halt  <= 1'b1;
              state <= ST_WAIT;
            end
            default: begin
              busy  <= 1'b0;
              error <= 1'b1;
              state <= ST_ERROR;
            end
          endcase
        end
        ST_DISPATCH: if (bus.cmd_ready) cmd_valid <= 1'b0;
        ST_SYNC:     if (bus.sync_grant) sync_request <= 1'b0;
        ST_WAIT: begin
          if (!exec_busy && halt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Later assignments win, so the retire path overrides the state above.
      if (adv) begin
        if (pc == '1) begin
          busy  <= 1'b0;
          error <= 1'b1;
          state <= ST_ERROR;
        end else begin
          pc       <= pc + PC_W'(1);
          imem_req <= 1'b1;
          tmo_cnt  <= TMO_LOAD;
          state    <= ST_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_tpc_cmd_sequencer.sv
// Self-checking bench for tpc_cmd_sequencer: an instruction-level interpreter
// predicts fetch addresses, dispatched payloads and final status.
module tb_tpc_cmd_sequencer;
  localparam int PC_W = 20;
  localparam int TMO  = 1024;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [PC_W-1:0] start_pc;
  logic            exec_busy;
  logic            busy;
  logic            done;
  logic            error;

  tpc_cmd_sequencer_if #(.PC_W(PC_W), .INSTR_W(32)) bus ();

  tpc_cmd_sequencer #(.PC_W(PC_W), .INSTR_W(32), .FETCH_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_pc  (start_pc),
    .exec_busy (exec_busy),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .bus       (bus)
  );

  typedef enum {R_DONE, R_ERROR} result_e;

  int          n_checks = 0;
  int          n_pass   = 0;
  longint      cyc      = 0;
  logic [31:0] mem [int unsigned];
  bit          mem_enable = 1;
  int          mem_lat  = 0;
  int          cmd_dly  = 0;
  int          sync_dly = 0;
  int unsigned exp_fetch [$];
  logic [27:0] exp_cmd [$];
  result_e     exp_result;
  longint      fetch_cyc [$];
  int          cmd_bursts [$];
  int          sync_bursts [$];
  int          n_xfer = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, summary %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_read(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return 32'h7000_0000;
  endfunction

  // Instruction-level interpreter of the program in mem.
  task automatic model_run(input int unsigned spc);
    int unsigned pc;
    logic [31:0] w;
    pc = spc;
    exp_fetch.delete();
    exp_cmd.delete();
    fetch_cyc.delete();
    cmd_bursts.delete();
    sync_bursts.delete();
    n_xfer = 0;
    exp_result = R_ERROR;
    for (int step = 0; step < 256; step++) begin
      w = mem_read(pc);
      exp_fetch.push_back(pc);
      if (w[31:28] == 4'hF) begin exp_result = R_DONE; return; end
      if (w[31:28] > 4'h3) begin exp_result = R_ERROR; return; end
      if (w[31:28] == 4'h1) exp_cmd.push_back(w[27:0]);
      if (pc == (1 << PC_W) - 1) begin exp_result = R_ERROR; return; end
      pc++;
    end
  endtask

  // Instruction memory: answers after mem_lat idle cycles of imem_req.
  initial begin : mem_responder
    int wait_n;
    wait_n = 0;
    bus.imem_valid = 0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_valid) begin
        bus.imem_valid = 0;
        wait_n = 0;
      end else if (bus.imem_req && mem_enable) begin
        if (wait_n >= mem_lat) begin
          bus.imem_valid = 1;
          bus.imem_rdata = mem_read(int'(bus.imem_addr));
        end else wait_n++;
      end else wait_n = 0;
    end
  end

  initial begin : cmd_sink
    int n;
    n = 0;
    bus.cmd_ready = 0;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        bus.cmd_ready = 0;
        n = 0;
      end else if (bus.cmd_valid) begin
        if (n >= cmd_dly) bus.cmd_ready = 1;
        else n++;
      end else n = 0;
    end
  end

  initial begin : sync_granter
    int n;
    n = 0;
    bus.sync_grant = 0;
    forever begin
      @(negedge clk);
      if (bus.sync_grant) begin
        bus.sync_grant = 0;
        n = 0;
      end else if (bus.sync_request) begin
        if (n >= sync_dly) bus.sync_grant = 1;
        else n++;
      end else n = 0;
    end
  end

  // Per-cycle compare against the interpreter and the handshake rules.
  initial begin : monitor
    logic p_req, p_val, p_cv, p_cr, p_sr, p_sg;
    logic [PC_W-1:0] p_addr;
    logic [27:0] p_data;
    int cmd_run, sync_run;
    p_req = 0; p_val = 0; p_cv = 0; p_cr = 0; p_sr = 0; p_sg = 0;
    p_addr = '0; p_data = '0; cmd_run = 0; sync_run = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        p_req = 0; p_val = 0; p_cv = 0; p_cr = 0; p_sr = 0; p_sg = 0;
        cmd_run = 0; sync_run = 0;
        continue;
      end
      check("out_exclusive",
            $countones({bus.imem_req, bus.cmd_valid, bus.sync_request}) <= 1, 1);
      if (p_req && !p_val) begin
        check("imem_req_held", bus.imem_req | error, 1);
        if (bus.imem_req) check("imem_addr_stable", bus.imem_addr, p_addr);
      end
      if (p_cv && !p_cr) begin
        check("cmd_valid_held", bus.cmd_valid, 1);
        check("cmd_data_stable", bus.cmd_data, p_data);
      end
      if (p_cv && p_cr) check("cmd_valid_drop", bus.cmd_valid, 0);
      if (p_sr) check("sync_request_level", bus.sync_request, !p_sg);
      if (bus.imem_req && bus.imem_valid) begin
        fetch_cyc.push_back(cyc);
        check("fetch_expected", exp_fetch.size() > 0, 1);
        if (exp_fetch.size() > 0) check("fetch_addr", bus.imem_addr, exp_fetch.pop_front());
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        n_xfer++;
        check("cmd_expected", exp_cmd.size() > 0, 1);
        if (exp_cmd.size() > 0) check("cmd_payload", bus.cmd_data, exp_cmd.pop_front());
      end
      if (bus.cmd_valid) cmd_run++;
      else if (cmd_run > 0) begin cmd_bursts.push_back(cmd_run); cmd_run = 0; end
      if (bus.sync_request) sync_run++;
      else if (sync_run > 0) begin sync_bursts.push_back(sync_run); sync_run = 0; end
      p_req = bus.imem_req; p_val = bus.imem_valid; p_addr = bus.imem_addr;
      p_cv = bus.cmd_valid; p_cr = bus.cmd_ready; p_data = bus.cmd_data;
      p_sr = bus.sync_request; p_sg = bus.sync_grant;
    end
  end

  task automatic launch(input int unsigned spc);
    model_run(spc);
    @(negedge clk);
    start = 1;
    start_pc = PC_W'(spc);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int i;
    i = 0;
    while (!(done || error) && i < budget) begin
      @(negedge clk);
      #2;
      i++;
    end
    check({name, "_finished"}, done || error, 1);
  endtask

  task automatic check_end(input string name);
    check({name, "_done"}, done, exp_result == R_DONE);
    check({name, "_error"}, error, exp_result == R_ERROR);
    check({name, "_busy"}, busy, 0);
    check({name, "_fetch_left"}, exp_fetch.size(), 0);
    check({name, "_cmd_left"}, exp_cmd.size(), 0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_error"}, error, 0);
    check({name, "_imem_req"}, bus.imem_req, 0);
    check({name, "_cmd_valid"}, bus.cmd_valid, 0);
    check({name, "_sync_request"}, bus.sync_request, 0);
  endtask

  initial begin : stimulus
    int n;
    start = 0; start_pc = '0; exec_busy = 0; rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1;

    // NOP then HALT at 0x100; start while busy is ignored
    mem.delete();
    mem[32'h100] = 32'h0000_0000;
    mem[32'h101] = 32'hF000_0000;
    mem_lat = 2;
    launch(32'h100);
    #1;
    check("t1_first_addr", bus.imem_addr, 32'h100);
    check("t1_imem_req", bus.imem_req, 1);
    check("t1_busy", busy, 1);
    @(negedge clk);
    start = 1; start_pc = 20'h200;
    @(negedge clk);
    start = 0;
    wait_end("t1", 100);
    check_end("t1");
    check("t1_done_lit", done, 1);
    check("t1_fetches", fetch_cyc.size(), 2);

    // NOP throughput with zero-latency memory
    mem.delete();
    mem[32'h40] = 32'h0000_0000;
    mem[32'h41] = 32'h0000_0000;
    mem[32'h42] = 32'hF000_0000;
    mem_lat = 0;
    launch(32'h40);
    wait_end("thru", 100);
    check_end("thru");
    check("thru_fetches", fetch_cyc.size(), 3);
    if (fetch_cyc.size() == 3) begin
      check("thru_gap0", fetch_cyc[1] - fetch_cyc[0], 2);
      check("thru_gap1", fetch_cyc[2] - fetch_cyc[1], 2);
    end

    // DISPATCH with cmd_ready held off 5 cycles
    mem.delete();
    mem[32'h10] = 32'h10AB_CDEF;
    mem[32'h11] = 32'hF000_0000;
    mem_lat = 1; cmd_dly = 5;
    launch(32'h10);
    n = 0;
    while (!bus.cmd_valid && n < 50) begin @(negedge clk); #2; n++; end
    check("disp_cmd_data", bus.cmd_data, 28'h0ABCDEF);
    wait_end("disp", 100);
    check_end("disp");
    check("disp_bursts", cmd_bursts.size(), 1);
    if (cmd_bursts.size() == 1) check("disp_valid_cycles", cmd_bursts[0], 6);
    check("disp_xfers", n_xfer, 1);

    // SYNC with grant delayed 10 cycles, then NOP, HALT
    mem.delete();
    mem[32'h20] = 32'h2000_0000;
    mem[32'h21] = 32'h0000_0000;
    mem[32'h22] = 32'hF000_0000;
    cmd_dly = 0; sync_dly = 10;
    launch(32'h20);
    wait_end("sync", 100);
    check_end("sync");
    check("sync_bursts", sync_bursts.size(), 1);
    if (sync_bursts.size() == 1) check("sync_req_cycles", sync_bursts[0], 11);
    check("sync_fetches", fetch_cyc.size(), 3);

    // WAIT held by exec_busy
    mem.delete();
    mem[32'h300] = 32'h3000_0000;
    mem[32'h301] = 32'hF000_0000;
    sync_dly = 0; exec_busy = 1;
    launch(32'h300);
    repeat (12) @(negedge clk);
    #2;
    check("wait_busy", busy, 1);
    check("wait_done", done, 0);
    check("wait_no_fetch", bus.imem_req, 0);
    exec_busy = 0;
    wait_end("wait", 100);
    check_end("wait");

    // Mixed program
    mem.delete();
    mem[32'h200] = 32'h1123_4567;
    mem[32'h201] = 32'h3000_0000;
    mem[32'h202] = 32'h2000_0000;
    mem[32'h203] = 32'h1000_0001;
    mem[32'h204] = 32'h0000_0000;
    mem[32'h205] = 32'hF000_0000;
    launch(32'h200);
    wait_end("mixed", 200);
    check_end("mixed");
    check("mixed_xfers", n_xfer, 2);

    // Illegal opcode, then a new start clears error
    mem.delete();
    mem[32'h30] = 32'h7000_0000;
    launch(32'h30);
    wait_end("badop", 100);
    check_end("badop");
    check("badop_error_lit", error, 1);
    check("badop_done_lit", done, 0);
    mem[32'h100] = 32'h0000_0000;
    mem[32'h101] = 32'hF000_0000;
    launch(32'h100);
    #1;
    check("restart_error_clr", error, 0);
    check("restart_busy", busy, 1);
    wait_end("restart", 100);
    check_end("restart");

    // Fetch timeout
    mem_enable = 0;
    launch(32'h50);
    n = 0;
    for (int i = 0; i < TMO + 50; i++) begin
      #1;
      if (error) break;
      if (bus.imem_req) n++;
      @(negedge clk);
    end
    check("tmo_req_cycles", n, TMO);
    check("tmo_error", error, 1);
    check("tmo_busy", busy, 0);
    check("tmo_req_drop", bus.imem_req, 0);
    mem_enable = 1;

    // PC overflow
    mem.delete();
    mem[32'hFFFFF] = 32'h0000_0000;
    launch(32'hFFFFF);
    wait_end("pcmax", 100);
    check_end("pcmax");
    check("pcmax_error_lit", error, 1);

    // Reset during DISPATCH
    mem.delete();
    mem[32'h60] = 32'h1000_0042;
    cmd_dly = 1000;
    launch(32'h60);
    n = 0;
    while (!bus.cmd_valid && n < 50) begin @(negedge clk); #2; n++; end
    check("rst_in_dispatch", bus.cmd_valid, 1);
    rst_n = 0;
    #1;
    check_quiet("rst_async");
    repeat (2) @(negedge clk);
    rst_n = 1;
    cmd_dly = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_quiet("post_rst");
    end
    mem[32'h100] = 32'h0000_0000;
    mem[32'h101] = 32'hF000_0000;
    launch(32'h100);
    wait_end("recover", 100);
    check_end("recover");
    check("recover_xfers", n_xfer, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
